issue_queue_free_list: RTL and testbench

Manages free issue-queue entry indices as a circular FIFO. Dispatch pops entries from it. Released entries are pushed back: these come from the wakeup pipeline register after the entry has woken its consumers. On recovery, the block also reclaims IQ entries flushed from the queue by scanning a one-hot flush vector over several cycles. Sits between dispatch and the scheduler's wakeup/release path.

---
 rtl/issue_queue_free_list_pkg.sv | 36 +++
 rtl/issue_queue_free_list_flush_scanner.sv | 68 ++++++
 rtl/issue_queue_free_list.sv | 209 ++++++++++++++++++++
 tb/tb_issue_queue_free_list.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_free_list_pkg.sv
// issue_queue_free_list_pkg
//   Shared scheduler types for the issue-queue free list and its flush
//   scanner: entry index / one-hot vector types, the free-count type, the
//   reclaim scanner state enum, sizing constants and a lowest-set-bit helper.
package issue_queue_free_list_pkg;

    localparam int ISSUE_QUEUE_ENTRY_NUM   = 16;
    localparam int ISSUE_QUEUE_INDEX_WIDTH = $clog2(ISSUE_QUEUE_ENTRY_NUM);
    localparam int DISPATCH_WIDTH          = 2;
    localparam int RELEASE_WIDTH           = 4;
    localparam int FLUSH_SCAN_WIDTH        = 2;
    localparam int FREE_LIST_COUNT_WIDTH   = ISSUE_QUEUE_INDEX_WIDTH + 1;
    // Release lanes first, then scan lanes: this is also the tail write order.
    localparam int FREE_LIST_PUSH_WIDTH    = RELEASE_WIDTH + FLUSH_SCAN_WIDTH;

    typedef logic [ISSUE_QUEUE_INDEX_WIDTH-1:0] IssueQueueIndexPath;
    typedef logic [ISSUE_QUEUE_ENTRY_NUM-1:0]   IssueQueueOneHotPath;
    typedef logic [FREE_LIST_COUNT_WIDTH-1:0]   FreeListCountPath;

    typedef enum logic [0:0] {
        FLS_IDLE = 1'b0,
        FLS_SCAN = 1'b1
    } FreeListScanState;

    // Index of the lowest set bit; 0 when the vector is empty (callers
    // qualify the result with |vec).
    function automatic IssueQueueIndexPath lowest_set_index(input IssueQueueOneHotPath vec);
        IssueQueueIndexPath idx;
        idx = '0;
        for (int i = ISSUE_QUEUE_ENTRY_NUM - 1; i >= 0; i--) begin
            if (vec[i]) idx = IssueQueueIndexPath'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/issue_queue_free_list_flush_scanner.sv
// issue_queue_flush_scanner
//   Reclaims issue-queue entries flushed by recovery. A flush vector is
//   captured on flush_start; while in FLS_SCAN the FLUSH_SCAN_WIDTH lowest
//   set bits are emitted each cycle as valid/index pairs and cleared. A
//   flush_start arriving during a scan is merged into the pending vector.
//   The scan is not affected by dispatch stall.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   flush_start       one-cycle capture pulse for flush_vector
//   flush_vector      one-hot-set vector of flushed entries
//   scan_valid        per scan lane: an index is being returned this cycle
//   scan_index        per scan lane entry index (flat, lane 0 in low bits)
//   scan_state        current FSM state (FLS_SCAN means busy)
module issue_queue_flush_scanner
    import issue_queue_free_list_pkg::*;
(
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            flush_start,
    input  logic [ISSUE_QUEUE_ENTRY_NUM-1:0]                flush_vector,
    output logic [FLUSH_SCAN_WIDTH-1:0]                     scan_valid,
    output logic [FLUSH_SCAN_WIDTH*ISSUE_QUEUE_INDEX_WIDTH-1:0] scan_index,
    output FreeListScanState                                scan_state
);

    FreeListScanState    state_q;
    IssueQueueOneHotPath scan_vector_q;
    IssueQueueOneHotPath remaining;
    IssueQueueOneHotPath scan_vector_next;

    // Peel off the lowest set bits one lane at a time; v & (v - 1) clears
    // the bit just emitted so the next lane sees the next-lowest one.
    always_comb begin
        remaining  = scan_vector_q;
        scan_valid = '0;
        scan_index = '0;
        if (state_q == FLS_SCAN) begin
            for (int k = 0; k < FLUSH_SCAN_WIDTH; k++) begin
                if (|remaining) begin
                    scan_valid[k] = 1'b1;
                    scan_index[k*ISSUE_QUEUE_INDEX_WIDTH +: ISSUE_QUEUE_INDEX_WIDTH] =
                        lowest_set_index(remaining);
                    remaining = remaining & (remaining - IssueQueueOneHotPath'(1));
                end
            end
        end
        // scan_vector_q is zero in FLS_IDLE, so this is a plain capture there
        // and a merge during a scan.
        scan_vector_next = remaining | (flush_start ? flush_vector : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FLS_IDLE;
            scan_vector_q <= '0;
        end else begin
            scan_vector_q <= scan_vector_next;
            case (state_q)
                FLS_IDLE: if (flush_start && (|flush_vector)) state_q <= FLS_SCAN;
                FLS_SCAN: if (scan_vector_next == '0)         state_q <= FLS_IDLE;
                default:                                      state_q <= FLS_IDLE;
            endcase
        end
    end

    assign scan_state = state_q;

endmodule

// File: rtl/issue_queue_free_list.sv
// issue_queue_free_list
//   Circular FIFO of free issue-queue entry indices. Dispatch pops from the
//   head; released entries (from the wakeup pipeline) and entries reclaimed
//   by the flush scanner are pushed at the tail, releases first.
//   Optional build macro ISSUE_QUEUE_FREE_LIST_CHECK_EN keeps an allocation
//   map and raises a sticky freeListError on double free, double allocation
//   or count overflow; without it freeListError is tied low.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   stall           dispatch stall, blocks allocation
//   allocate        per-lane allocation request, contiguous from lane 0
//   allocatedPtr    per-lane granted index (flat), combinational from head
//   allocatable     at least DISPATCH_WIDTH free and no reclaim scan running
//   freeCount       registered number of free entries
//   releaseEntry    per-lane release valid
//   releasePtr      per-lane released index (flat)
//   flushStart      capture pulse for flushIQ_Entry
//   flushIQ_Entry   one-hot-set vector of flushed entries
//   flushBusy       reclaim scan in progress
//   freeListError   sticky consistency error (checking build only)
//
// Allocation handshake: allocate[i] is a request and allocatable is the
// ready; lane i is granted exactly when allocate[i], allocatable and !stall
// are all high in the same cycle, and allocatedPtr[i] is valid in that cycle.
module issue_queue_free_list
    import issue_queue_free_list_pkg::*;
(
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             stall,
    input  logic [DISPATCH_WIDTH-1:0]                        allocate,
    output logic [DISPATCH_WIDTH*ISSUE_QUEUE_INDEX_WIDTH-1:0] allocatedPtr,
    output logic                                             allocatable,
    output logic [FREE_LIST_COUNT_WIDTH-1:0]                 freeCount,
    input  logic [RELEASE_WIDTH-1:0]                         releaseEntry,
    input  logic [RELEASE_WIDTH*ISSUE_QUEUE_INDEX_WIDTH-1:0] releasePtr,
    input  logic                                             flushStart,
    input  logic [ISSUE_QUEUE_ENTRY_NUM-1:0]                 flushIQ_Entry,
    output logic                                             flushBusy,
    output logic                                             freeListError
);

    localparam logic [FREE_LIST_COUNT_WIDTH:0] SUM_ONE   = (FREE_LIST_COUNT_WIDTH+1)'(1);
    localparam logic [FREE_LIST_COUNT_WIDTH:0] SUM_LIMIT = (FREE_LIST_COUNT_WIDTH+1)'(ISSUE_QUEUE_ENTRY_NUM);

    IssueQueueIndexPath ram [ISSUE_QUEUE_ENTRY_NUM];
    IssueQueueIndexPath head_q;
    IssueQueueIndexPath tail_q;
    IssueQueueIndexPath tail_next;
    FreeListCountPath   count_q;
    FreeListCountPath   count_next;

    FreeListScanState                                    scan_state;
    logic [FLUSH_SCAN_WIDTH-1:0]                         scan_valid;
    logic [FLUSH_SCAN_WIDTH*ISSUE_QUEUE_INDEX_WIDTH-1:0] scan_index;

    logic                              alloc_contig;
    logic                              pop_fire;
    logic [DISPATCH_WIDTH-1:0]         pop_valid;
    logic [FREE_LIST_COUNT_WIDTH:0]    n_pop;
    logic [FREE_LIST_PUSH_WIDTH-1:0]   push_valid;
    IssueQueueIndexPath                push_index [FREE_LIST_PUSH_WIDTH];
    IssueQueueIndexPath                push_addr  [FREE_LIST_PUSH_WIDTH];
    logic [FREE_LIST_COUNT_WIDTH:0]    n_push;
    logic [FREE_LIST_COUNT_WIDTH:0]    count_sum;
    logic                              overflow;

    issue_queue_flush_scanner u_scanner (
        .clk          (clk),
        .rst          (rst),
        .flush_start  (flushStart),
        .flush_vector (flushIQ_Entry),
        .scan_valid   (scan_valid),
        .scan_index   (scan_index),
        .scan_state   (scan_state)
    );

    assign flushBusy   = (scan_state == FLS_SCAN);
    assign allocatable = (count_q >= FreeListCountPath'(DISPATCH_WIDTH)) && !flushBusy;
    assign freeCount   = count_q;

    // ---------------------------------------------------------------- pop side
    always_comb begin
        // A request with a hole (lane i set, lane i-1 clear) is dropped whole.
        alloc_contig = 1'b1;
        for (int i = 1; i < DISPATCH_WIDTH; i++) begin
            if (allocate[i] && !allocate[i-1]) alloc_contig = 1'b0;
        end
        pop_fire  = !stall && allocatable && alloc_contig;
        pop_valid = '0;
        n_pop     = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            allocatedPtr[i*ISSUE_QUEUE_INDEX_WIDTH +: ISSUE_QUEUE_INDEX_WIDTH] =
                ram[head_q + IssueQueueIndexPath'(i)];
            if (pop_fire && allocate[i]) begin
                pop_valid[i] = 1'b1;
                n_pop        = n_pop + SUM_ONE;
            end
        end
    end

    // --------------------------------------------------------------- push side
    // Release lanes and scan lanes are laid out in one slot list and
    // compacted onto consecutive tail addresses in slot order.
    always_comb begin
        push_valid = '0;
        n_push     = '0;
        tail_next  = tail_q;
        for (int k = 0; k < FREE_LIST_PUSH_WIDTH; k++) begin
            push_index[k] = '0;
            push_addr[k]  = '0;
        end
        for (int j = 0; j < RELEASE_WIDTH; j++) begin
            push_valid[j] = releaseEntry[j];
            push_index[j] = releasePtr[j*ISSUE_QUEUE_INDEX_WIDTH +: ISSUE_QUEUE_INDEX_WIDTH];
        end
        for (int s = 0; s < FLUSH_SCAN_WIDTH; s++) begin
            push_valid[RELEASE_WIDTH+s] = scan_valid[s];
            push_index[RELEASE_WIDTH+s] =
                scan_index[s*ISSUE_QUEUE_INDEX_WIDTH +: ISSUE_QUEUE_INDEX_WIDTH];
        end
        for (int k = 0; k < FREE_LIST_PUSH_WIDTH; k++) begin
            push_addr[k] = tail_next;
            if (push_valid[k]) begin
                tail_next = tail_next + IssueQueueIndexPath'(1);
                n_push    = n_push + SUM_ONE;
            end
        end
    end

    // ------------------------------------------------------------------- count
    // Pops only fire with count >= DISPATCH_WIDTH, so the subtraction cannot
    // underflow; the extra top bit exposes a push overflow.
    always_comb begin
        count_sum  = {1'b0, count_q} - n_pop + n_push;
        overflow   = (count_sum > SUM_LIMIT);
        count_next = overflow ? FreeListCountPath'(ISSUE_QUEUE_ENTRY_NUM)
                              : count_sum[FREE_LIST_COUNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ISSUE_QUEUE_ENTRY_NUM; i++) begin
                ram[i] <= IssueQueueIndexPath'(i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= FreeListCountPath'(ISSUE_QUEUE_ENTRY_NUM);
        end else begin
            for (int k = 0; k < FREE_LIST_PUSH_WIDTH; k++) begin
                if (push_valid[k]) ram[push_addr[k]] <= push_index[k];
            end
            head_q  <= head_q + n_pop[ISSUE_QUEUE_INDEX_WIDTH-1:0];
            tail_q  <= tail_next;
            count_q <= count_next;
        end
    end

    // --------------------------------------------------------- optional checks
`ifdef ISSUE_QUEUE_FREE_LIST_CHECK_EN
    IssueQueueOneHotPath allocated_map_q;
    IssueQueueOneHotPath allocated_map_next;
    logic                error_event;
    logic                error_q;

    // Checks use the map as it stood at the start of the cycle; a released
    // entry cannot be popped in the same cycle since there is no bypass.
    always_comb begin
        allocated_map_next = allocated_map_q;
        error_event        = overflow;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (pop_valid[i]) begin
                if (allocated_map_q[allocatedPtr[i*ISSUE_QUEUE_INDEX_WIDTH +: ISSUE_QUEUE_INDEX_WIDTH]])
                    error_event = 1'b1;
                allocated_map_next[allocatedPtr[i*ISSUE_QUEUE_INDEX_WIDTH +: ISSUE_QUEUE_INDEX_WIDTH]] = 1'b1;
            end
        end
        for (int k = 0; k < FREE_LIST_PUSH_WIDTH; k++) begin
            if (push_valid[k]) begin
                if (!allocated_map_q[push_index[k]]) error_event = 1'b1;
                allocated_map_next[push_index[k]] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            allocated_map_q <= '0;
            error_q         <= 1'b0;
        end else begin
            allocated_map_q <= allocated_map_next;
            if (error_event) error_q <= 1'b1;
        end
    end

    assign freeListError = error_q;
`else
    assign freeListError = 1'b0;
`endif

    // --------------------------------------------------------------- assertions
    a_alloc_contiguous: assert property (@(posedge clk) disable iff (!rst)
        (!stall && (|allocate)) |-> alloc_contig);
    a_alloc_when_ready: assert property (@(posedge clk) disable iff (!rst)
        (!stall && (|allocate)) |-> allocatable);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !overflow);

endmodule

// File: tb/tb_issue_queue_free_list.sv
module tb_issue_queue_free_list;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  allocate;
    logic [7:0]  allocatedPtr;
    logic        allocatable;
    logic [4:0]  freeCount;
    logic [3:0]  releaseEntry;
    logic [15:0] releasePtr;
    logic        flushStart;
    logic [15:0] flushIQ_Entry;
    logic        flushBusy;
    logic        freeListError;

    issue_queue_free_list dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .allocate      (allocate),
        .allocatedPtr  (allocatedPtr),
        .allocatable   (allocatable),
        .freeCount     (freeCount),
        .releaseEntry  (releaseEntry),
        .releasePtr    (releasePtr),
        .flushStart    (flushStart),
        .flushIQ_Entry (flushIQ_Entry),
        .flushBusy     (flushBusy),
        .freeListError (freeListError)
    );

    // ------------------------------------------------------------ clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------- scoreboard
    int          n_checks;
    int          n_bad;
    int          free_q[$];   // expected free indices in FIFO order
    int          held[$];     // indices currently owned by the bench
    logic [15:0] m_pend;      // flushed entries still to be reclaimed
    logic        m_busy;
    logic [15:0] m_map;       // 1 = allocated
    logic        m_err;
    logic [15:0] seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        held.delete();
        for (int i = 0; i < 16; i++) free_q.push_back(i);
        m_pend = '0;
        m_busy = 1'b0;
        m_map  = '0;
        m_err  = 1'b0;
    endtask

    task automatic delete_held(input int v);
        for (int i = 0; i < held.size(); i++) begin
            if (held[i] == v) begin
                held.delete(i);
                break;
            end
        end
    endtask

    task automatic pick_held(output int v);
        int idx;
        idx = $urandom_range(0, held.size() - 1);
        v   = held[idx];
        held.delete(idx);
    endtask

    // ------------------------------------------------------------ driver
    // Drives one cycle from a negedge: apply inputs, check outputs against
    // the model, advance the model, wait for the next negedge.
    task automatic cycle(input logic [1:0] a, input logic [3:0] re, input logic [15:0] rp,
                         input logic fs, input logic [15:0] fv, input logic st);
        int   sz;
        int   v;
        int   took;
        logic can;
        logic contig;
        allocate      = a;
        releaseEntry  = re;
        releasePtr    = rp;
        flushStart    = fs;
        flushIQ_Entry = fv;
        stall         = st;
        #1;
        sz  = free_q.size();
        can = (sz >= 2) && !m_busy;
        check("free_count",  32'(freeCount), sz);
        check("allocatable", 32'(allocatable), 32'(can));
        check("flush_busy",  32'(flushBusy), 32'(m_busy));
        for (int i = 0; i < 2; i++) begin
            if (i < sz) check("alloc_ptr", 32'(allocatedPtr[i*4 +: 4]), free_q[i]);
        end
`ifdef ISSUE_QUEUE_FREE_LIST_CHECK_EN
        check("free_list_error", 32'(freeListError), 32'(m_err));
`else
        check("free_list_error", 32'(freeListError), 0);
`endif
        if (rst) begin
            contig = !(a[1] && !a[0]);
            for (int i = 0; i < 2; i++) begin
                if (a[i] && !st && can && contig) begin
                    seen[allocatedPtr[i*4 +: 4]] = 1'b1;
                    v = free_q.pop_front();
                    if (m_map[v]) m_err = 1'b1;
                    m_map[v] = 1'b1;
                    held.push_back(v);
                end
            end
            for (int j = 0; j < 4; j++) begin
                if (re[j]) begin
                    v = int'(rp[j*4 +: 4]);
                    if (!m_map[v]) m_err = 1'b1;
                    m_map[v] = 1'b0;
                    free_q.push_back(v);
                end
            end
            if (m_busy) begin
                took = 0;
                for (int b = 0; b < 16; b++) begin
                    if (m_pend[b] && took < 2) begin
                        if (!m_map[b]) m_err = 1'b1;
                        m_map[b]  = 1'b0;
                        m_pend[b] = 1'b0;
                        free_q.push_back(b);
                        took++;
                    end
                end
            end
            if (fs) m_pend = m_pend | fv;
            m_busy = (m_pend != '0);
            if (free_q.size() > 16) m_err = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(2'b00, 4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int          v;
        int          busy_cycles;
        logic [3:0]  re;
        logic [15:0] rp;
        logic [15:0] fv;
        logic [1:0]  a;
        logic        fs;

        n_checks = 0;
        n_bad    = 0;
        seen     = '0;
        rst      = 1'b0;
        model_reset();
        allocate = '0; releaseEntry = '0; releasePtr = '0;
        flushStart = 1'b0; flushIQ_Entry = '0; stall = 1'b0;
        @(negedge clk);
        idle();                     // reset-state checks while rst is low
        rst = 1'b1;

        // Fill: eight double allocations, then empty.
        repeat (8) cycle(2'b11, 4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        idle();

        // Release 5 and 9 on lanes 0 and 2; they come back in that order.
        delete_held(5);
        delete_held(9);
        cycle(2'b00, 4'b0101, {4'd0, 4'd9, 4'd0, 4'd5}, 1'b0, 16'h0000, 1'b0);
        cycle(2'b11, 4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

        // Steady state at eight free entries so head and tail wrap.
        repeat (2) begin
            rp = '0;
            for (int j = 0; j < 4; j++) begin
                pick_held(v);
                rp[j*4 +: 4] = 4'(v);
            end
            cycle(2'b00, 4'b1111, rp, 1'b0, 16'h0000, 1'b0);
        end
        repeat (40) begin
            rp = '0;
            pick_held(v); rp[7:4]   = 4'(v);
            pick_held(v); rp[15:12] = 4'(v);
            cycle(2'b11, 4'b1010, rp, 1'b0, 16'h0000, 1'b0);
        end

        // Drain and confirm every index shows up exactly once overall.
        seen = '0;
        foreach (held[i]) seen[held[i]] = 1'b1;
        repeat (4) cycle(2'b11, 4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("no_index_lost", 32'(seen), 32'h0000_FFFF);

        // Flush 0x00F3 with everything allocated: three scan cycles.
        fv = 16'h00F3;
        for (int b = 0; b < 16; b++) if (fv[b]) delete_held(b);
        cycle(2'b00, 4'b0000, 16'h0000, 1'b1, fv, 1'b0);
        busy_cycles = 0;
        for (int c = 0; c < 8; c++) begin
            if (flushBusy) busy_cycles++;
            idle();
        end
        check("flush_scan_cycles", 32'(busy_cycles), 3);

        // Merge a second flush and a release into a running scan.
        repeat (3) cycle(2'b11, 4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        delete_held(0);
        delete_held(1);
        cycle(2'b00, 4'b0000, 16'h0000, 1'b1, 16'h0003, 1'b0);
        delete_held(8);
        delete_held(12);
        cycle(2'b00, 4'b0001, {12'h000, 4'd12}, 1'b1, 16'h0100, 1'b0);
        repeat (3) idle();
        repeat (2) cycle(2'b11, 4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

        // Randomized traffic: stalls, partial allocations, releases, flushes.
        repeat (400) begin
            if (free_q.size() >= 2 && !m_busy) begin
                case ($urandom_range(0, 2))
                    0:       a = 2'b00;
                    1:       a = 2'b01;
                    default: a = 2'b11;
                endcase
            end else begin
                a = 2'b00;
            end
            re = '0;
            rp = '0;
            for (int j = 0; j < 4; j++) begin
                if (held.size() > 0 && $urandom_range(0, 2) == 0) begin
                    pick_held(v);
                    re[j] = 1'b1;
                    rp[j*4 +: 4] = 4'(v);
                end
            end
            fs = 1'b0;
            fv = '0;
            if (held.size() > 0 && $urandom_range(0, 15) == 0) begin
                fs = 1'b1;
                for (int f = 0; f < 5; f++) begin
                    if (held.size() > 0 && $urandom_range(0, 1) == 1) begin
                        pick_held(v);
                        fv[v] = 1'b1;
                    end
                end
            end
            cycle(a, re, rp, fs, fv, 1'($urandom_range(0, 3) == 0));
        end
        repeat (12) idle();

        // Double free of entry 3 after a fresh reset.
        rst = 1'b0;
        model_reset();
        idle();
        rst = 1'b1;
        repeat (2) cycle(2'b11, 4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        delete_held(3);
        cycle(2'b00, 4'b0001, 16'h0003, 1'b0, 16'h0000, 1'b0);
        cycle(2'b00, 4'b0001, 16'h0003, 1'b0, 16'h0000, 1'b0);
        repeat (3) idle();
        rst = 1'b0;
        model_reset();
        idle();
        rst = 1'b1;
        idle();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
